agc_core: RTL and testbench

AGC_CORE -- requirements
Module: agc_core

---
 rtl/agc_pkg.sv | 37 +++
 rtl/agc_ones_add.sv | 16 +
 rtl/agc_core.sv | 144 ++++++++++++++
 tb/tb_agc_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// AGC core shared types and constants.
// Opcode, sub-opcode and sequencer state encodings live here.
package agc_pkg;

  typedef enum logic [2:0] {
    OP_TC   = 3'd0,
    OP_CA   = 3'd1,
    OP_CS   = 3'd2,
    OP_AD   = 3'd3,
    OP_MASK = 3'd4,
    OP_TS   = 3'd5,
    OP_BZF  = 3'd6,
    OP_EXT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    SUB_HALT  = 3'd0,
    SUB_READ  = 3'd1,
    SUB_WRITE = 3'd2
  } subop_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_e;

  localparam logic [11:0] RESET_PC       = 12'h800;
  localparam logic [11:0] ERASABLE_LIMIT = 12'h400;
  localparam logic [14:0] MINUS_ZERO     = 15'h7FFF;

  function automatic logic is_erasable(input logic [11:0] k);
    return k < ERASABLE_LIMIT;
  endfunction

endpackage

// File: rtl/agc_ones_add.sv
// 15-bit ones'-complement adder.
// The carry out of bit 14 is folded back into bit 0.
module agc_ones_add
  import agc_pkg::*;
(
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic [14:0] sum
);

  logic [15:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign sum = raw[14:0] + {14'd0, raw[15]};

endmodule

// File: rtl/agc_core.sv
// Minimal AGC-style accumulator core.
// Three-cycle fetch/decode/exec sequencer over synchronous memories.
module agc_core
  import agc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] ROM_pc_data,
  input  logic [14:0] ROM_constant_data,
  input  logic [14:0] RAM_read_data,
  input  logic [14:0] IO_read_data,
  output logic [13:0] ROM_pc_address,
  output logic [13:0] ROM_constant_address,
  output logic [10:0] RAM_read_address,
  output logic [10:0] RAM_write_address,
  output logic [14:0] RAM_write_data,
  output logic        RAM_write_en,
  output logic [2:0]  IO_read_sel,
  output logic [2:0]  IO_write_sel,
  output logic [14:0] IO_write_data,
  output logic        IO_write_en,
  output logic        stall,
  output logic        halt
);

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [14:0] a_q, a_d;
  logic [14:0] ir_q, ir_d;

  opcode_e     op;
  logic [2:0]  subop;
  logic [11:0] k;
  logic [11:0] dk;
  logic        k_erasable;
  logic [14:0] m;
  logic [14:0] ad_sum;

  assign op         = opcode_e'(ir_q[14:12]);
  assign subop      = ir_q[11:9];
  assign k          = ir_q[11:0];
  assign dk         = ROM_pc_data[11:0];
  assign k_erasable = is_erasable(k);
  assign m          = k_erasable ? RAM_read_data : ROM_constant_data;

  agc_ones_add u_add (
    .a   (a_q),
    .b   (m),
    .sum (ad_sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      a_q     <= 15'd0;
      ir_q    <= 15'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    pc_d                 = pc_q;
    a_d                  = a_q;
    ir_d                 = ir_q;
    ROM_pc_address       = {2'b00, pc_q};
    ROM_constant_address = 14'd0;
    RAM_read_address     = 11'd0;
    RAM_write_address    = 11'd0;
    RAM_write_data       = 15'd0;
    RAM_write_en         = 1'b0;
    IO_read_sel          = 3'd0;
    IO_write_sel         = 3'd0;
    IO_write_data        = 15'd0;
    IO_write_en          = 1'b0;
    stall                = 1'b0;
    halt                 = 1'b0;

    unique case (state_q)
      ST_FETCH: state_d = ST_DECODE;

      // Operand address comes straight from the fetched word,
      // so data is ready by EXEC.
      ST_DECODE: begin
        ir_d        = ROM_pc_data;
        state_d     = ST_EXEC;
        IO_read_sel = dk[2:0];
        if (is_erasable(dk))
          RAM_read_address = {1'b0, dk[9:0]};
        else
          ROM_constant_address = {2'b00, dk};
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 12'd1;
        unique case (op)
          OP_TC:   pc_d = k;
          OP_CA:   a_d  = m;
          OP_CS:   a_d  = ~m;
          OP_AD:   a_d  = ad_sum;
          OP_MASK: a_d  = a_q & m;
          OP_TS: begin
            if (k_erasable) begin
              RAM_write_en      = 1'b1;
              RAM_write_address = {1'b0, k[9:0]};
              RAM_write_data    = a_q;
            end
          end
          OP_BZF: begin
            if (a_q == 15'd0 || a_q == MINUS_ZERO)
              pc_d = k;
          end
          OP_EXT: begin
            case (subop)
              SUB_HALT: begin
                state_d = ST_HALTED;
                pc_d    = pc_q;
              end
              SUB_READ:  a_d = IO_read_data;
              SUB_WRITE: begin
                IO_write_en   = 1'b1;
                IO_write_sel  = k[2:0];
                IO_write_data = a_q;
              end
              default: ;
            endcase
          end
        endcase
      end

      ST_HALTED: begin
        stall = 1'b1;
        halt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_agc_core.sv
// Directed self-checking bench for agc_core.
// Behavioural synchronous ROM/RAM/IO models surround the core.
module tb_agc_core;

  logic        clock;
  logic        reset;
  logic [14:0] ROM_pc_data;
  logic [14:0] ROM_constant_data;
  logic [14:0] RAM_read_data;
  logic [14:0] IO_read_data;
  logic [13:0] ROM_pc_address;
  logic [13:0] ROM_constant_address;
  logic [10:0] RAM_read_address;
  logic [10:0] RAM_write_address;
  logic [14:0] RAM_write_data;
  logic        RAM_write_en;
  logic [2:0]  IO_read_sel;
  logic [2:0]  IO_write_sel;
  logic [14:0] IO_write_data;
  logic        IO_write_en;
  logic        stall;
  logic        halt;

  logic [14:0] rom [0:16383];
  logic [14:0] ram [0:2047];
  logic [14:0] io  [0:7];

  int checks = 0;
  int errors = 0;
  int ram_we_n = 0;
  int io_we_n = 0;
  int both_n = 0;

  agc_core dut (
    .clock                (clock),
    .reset                (reset),
    .ROM_pc_data          (ROM_pc_data),
    .ROM_constant_data    (ROM_constant_data),
    .RAM_read_data        (RAM_read_data),
    .IO_read_data         (IO_read_data),
    .ROM_pc_address       (ROM_pc_address),
    .ROM_constant_address (ROM_constant_address),
    .RAM_read_address     (RAM_read_address),
    .RAM_write_address    (RAM_write_address),
    .RAM_write_data       (RAM_write_data),
    .RAM_write_en         (RAM_write_en),
    .IO_read_sel          (IO_read_sel),
    .IO_write_sel         (IO_write_sel),
    .IO_write_data        (IO_write_data),
    .IO_write_en          (IO_write_en),
    .stall                (stall),
    .halt                 (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    ROM_pc_data       <= rom[ROM_pc_address];
    ROM_constant_data <= rom[ROM_constant_address];
    RAM_read_data     <= ram[RAM_read_address];
    IO_read_data      <= io[IO_read_sel];
    if (RAM_write_en)
      ram[RAM_write_address] <= RAM_write_data;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (RAM_write_en) ram_we_n++;
      if (IO_write_en) io_we_n++;
      if (RAM_write_en && IO_write_en) both_n++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check fetch address, then advance to the EXEC cycle.
  task automatic fetch(input string tag, input logic [13:0] pc);
    chk({tag, " fetch"}, 16'(ROM_pc_address), 16'(pc));
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic ts_chk(input string tag, input logic [10:0] addr,
                        input logic [14:0] data);
    chk({tag, " we"}, 16'(RAM_write_en), 16'd1);
    chk({tag, " waddr"}, 16'(RAM_write_address), 16'(addr));
    chk({tag, " wdata"}, 16'(RAM_write_data), 16'(data));
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 16384; i++) rom[i] = 15'd0;
    for (int i = 0; i < 2048; i++) ram[i] = 15'd0;
    for (int i = 0; i < 8; i++) io[i] = 15'd0;
    io[3] = 15'h0ABC;

    rom[14'h800] = 15'h1900;
    rom[14'h801] = 15'h5010;
    rom[14'h802] = 15'h1901;
    rom[14'h803] = 15'h3902;
    rom[14'h804] = 15'h5011;
    rom[14'h805] = 15'h1903;
    rom[14'h806] = 15'h3904;
    rom[14'h807] = 15'h5012;
    rom[14'h808] = 15'h6A00;
    rom[14'hA00] = 15'h1905;
    rom[14'hA01] = 15'h6A00;
    rom[14'hA02] = 15'h1906;
    rom[14'hA03] = 15'h7405;
    rom[14'hA04] = 15'h7203;
    rom[14'hA05] = 15'h5020;
    rom[14'hA06] = 15'h5C00;
    rom[14'hA07] = 15'h1010;
    rom[14'hA08] = 15'h4907;
    rom[14'hA09] = 15'h5021;
    rom[14'hA0A] = 15'h2908;
    rom[14'hA0B] = 15'h5022;
    rom[14'hA0C] = 15'h0FFF;
    rom[14'hFFF] = 15'h1905;
    rom[14'h000] = 15'h0B00;
    rom[14'hB00] = 15'h7000;
    rom[14'h900] = 15'h0005;
    rom[14'h901] = 15'h7FFE;
    rom[14'h902] = 15'h0002;
    rom[14'h903] = 15'h0003;
    rom[14'h904] = 15'h7FFC;
    rom[14'h905] = 15'h0001;
    rom[14'h906] = 15'h1234;
    rom[14'h907] = 15'h000C;
    rom[14'h908] = 15'h7FF0;

    repeat (2) @(negedge clock);
    chk("rst pc_addr", 16'(ROM_pc_address), 16'h0800);
    chk("rst halt", 16'(halt), 16'd0);
    chk("rst stall", 16'(stall), 16'd0);
    chk("rst ram_we", 16'(RAM_write_en), 16'd0);
    chk("rst const_addr", 16'(ROM_constant_address), 16'd0);
    reset = 1'b0;

    chk("i0 fetch", 16'(ROM_pc_address), 16'h0800);
    chk("i0 stall", 16'(stall), 16'd0);
    @(negedge clock);
    chk("i0 const_addr", 16'(ROM_constant_address), 16'h0900);
    chk("i0 ram_raddr", 16'(RAM_read_address), 16'd0);
    @(negedge clock);
    chk("i0 ram_we", 16'(RAM_write_en), 16'd0);
    @(negedge clock);
    fetch("i1", 14'h801); ts_chk("ts010", 11'h010, 15'h0005);
    @(negedge clock);
    fetch("i2", 14'h802); @(negedge clock);
    fetch("i3", 14'h803); @(negedge clock);
    fetch("i4", 14'h804); ts_chk("ad_carry", 11'h011, 15'h0001);
    @(negedge clock);
    fetch("i5", 14'h805); @(negedge clock);
    fetch("i6", 14'h806); @(negedge clock);
    fetch("i7", 14'h807); ts_chk("ad_mz", 11'h012, 15'h7FFF);
    @(negedge clock);
    fetch("i8", 14'h808); @(negedge clock);
    fetch("bzf_taken", 14'hA00); @(negedge clock);
    fetch("i10", 14'hA01); @(negedge clock);
    fetch("bzf_not", 14'hA02); @(negedge clock);
    fetch("i12", 14'hA03);
    chk("wr io_we", 16'(IO_write_en), 16'd1);
    chk("wr sel", 16'(IO_write_sel), 16'd5);
    chk("wr data", 16'(IO_write_data), 16'h1234);
    chk("wr ram_we", 16'(RAM_write_en), 16'd0);
    @(negedge clock);
    chk("after wr io_we", 16'(IO_write_en), 16'd0);
    chk("i13 fetch", 16'(ROM_pc_address), 16'h0A04);
    @(negedge clock);
    chk("rd sel", 16'(IO_read_sel), 16'd3);
    @(negedge clock);
    @(negedge clock);
    fetch("i14", 14'hA05); ts_chk("rd_val", 11'h020, 15'h0ABC);
    @(negedge clock);
    fetch("i15", 14'hA06);
    chk("ts_fixed we", 16'(RAM_write_en), 16'd0);
    @(negedge clock);
    chk("i16 fetch", 16'(ROM_pc_address), 16'h0A07);
    @(negedge clock);
    chk("ca ram_raddr", 16'(RAM_read_address), 16'h0010);
    @(negedge clock);
    @(negedge clock);
    fetch("i17", 14'hA08); @(negedge clock);
    fetch("i18", 14'hA09); ts_chk("mask", 11'h021, 15'h0004);
    @(negedge clock);
    fetch("i19", 14'hA0A); @(negedge clock);
    fetch("i20", 14'hA0B); ts_chk("cs", 11'h022, 15'h000F);
    @(negedge clock);
    fetch("i21", 14'hA0C); @(negedge clock);
    fetch("tc_fff", 14'hFFF); @(negedge clock);
    fetch("pc_wrap", 14'h000); @(negedge clock);
    fetch("halt_instr", 14'hB00); @(negedge clock);

    chk("halt", 16'(halt), 16'd1);
    chk("halt stall", 16'(stall), 16'd1);
    repeat (6) @(negedge clock);
    chk("halt held", 16'(halt), 16'd1);
    chk("stall held", 16'(stall), 16'd1);
    chk("halt ram_we", 16'(RAM_write_en), 16'd0);
    chk("halt pc_addr", 16'(ROM_pc_address), 16'h0B00);
    chk("ram_we count", 16'(ram_we_n), 16'd6);
    chk("io_we count", 16'(io_we_n), 16'd1);
    chk("both strobes", 16'(both_n), 16'd0);

    reset = 1'b1;
    #1;
    chk("hrst halt", 16'(halt), 16'd0);
    chk("hrst stall", 16'(stall), 16'd0);
    chk("hrst pc_addr", 16'(ROM_pc_address), 16'h0800);
    @(negedge clock);
    reset = 1'b0;
    chk("restart fetch", 16'(ROM_pc_address), 16'h0800);
    @(negedge clock);
    chk("restart decode", 16'(ROM_constant_address), 16'h0900);
    reset = 1'b1;
    #1;
    chk("midrst const", 16'(ROM_constant_address), 16'd0);
    chk("midrst pc_addr", 16'(ROM_pc_address), 16'h0800);
    @(negedge clock);
    reset = 1'b0;
    fetch("r0", 14'h800); @(negedge clock);
    fetch("r1", 14'h801); ts_chk("r_ts010", 11'h010, 15'h0005);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
